// File: rtl/simpleserial_pkg.sv
// Shared types and character constants for the simple serial command receiver.
package simpleserial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HEX   = 2'd1,
    ST_EOL   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  typedef enum logic {
    TGT_KEY = 1'b0,
    TGT_PT  = 1'b1
  } target_e;

  localparam logic [7:0] CMD_KEY = 8'h6B;
  localparam logic [7:0] CMD_PT  = 8'h70;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;

  function automatic logic is_cmd_char(input logic [7:0] b);
    return (b == CMD_KEY) || (b == CMD_PT);
  endfunction

  function automatic target_e cmd_target(input logic [7:0] b);
    return (b == CMD_PT) ? TGT_PT : TGT_KEY;
  endfunction

endpackage

// File: rtl/simpleserial_rx_ascii_hex_decode.sv
// Combinational ASCII hex digit decoder; case-insensitive, flags non-hex bytes.
module ascii_hex_decode (
  input  logic [7:0] char_i,
  output logic       valid_o,
  output logic [3:0] nibble_o
);

  logic [7:0] lower_s;

  assign lower_s = char_i | 8'h20;

  // Letters are folded to lower case; their low nibble plus 9 gives 10..15.
  always_comb begin
    valid_o  = 1'b0;
    nibble_o = 4'h0;
    if ((char_i >= 8'h30) && (char_i <= 8'h39)) begin
      valid_o  = 1'b1;
      nibble_o = char_i[3:0];
    end else if ((lower_s >= 8'h61) && (lower_s <= 8'h66)) begin
      valid_o  = 1'b1;
      nibble_o = char_i[3:0] + 4'd9;
    end else begin
      valid_o  = 1'b0;
      nibble_o = 4'h0;
    end
  end

endmodule

// File: rtl/simpleserial_rx.sv
// Parses "k<hex>\n" / "p<hex>\n" commands from a UART byte stream into key/pt payloads.
module simpleserial_rx
  import simpleserial_pkg::*;
#(
  parameter int DATA_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_ready,
  input  logic                    rx_data_error,
  input  logic                    rx_endofpacket,
  output logic [8*DATA_BYTES-1:0] key,
  output logic                    key_valid,
  output logic [8*DATA_BYTES-1:0] pt,
  output logic                    pt_valid,
  output logic                    cmd_error,
  output logic                    busy
);

  localparam int W       = 8 * DATA_BYTES;
  localparam int NIBBLES = 2 * DATA_BYTES;
  localparam int CW      = $clog2(NIBBLES) + 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);
  localparam logic [CW-1:0] MAX_NIB  = CW'(NIBBLES);

  state_e          state_q, state_d, mid_state_s;
  target_e         target_q, target_d;
  logic [W-1:0]    asm_q, asm_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    key_q, key_d;
  logic [W-1:0]    pt_q, pt_d;
  logic            key_valid_q, key_valid_d;
  logic            pt_valid_q, pt_valid_d;
  logic            cmd_error_q, cmd_error_d;

  logic            byte_ok_s;
  logic            byte_bad_s;
  logic            is_lf_s;
  logic            hex_valid_s;
  logic [3:0]      hex_nib_s;

  ascii_hex_decode u_hex (
    .char_i   (rx_data),
    .valid_o  (hex_valid_s),
    .nibble_o (hex_nib_s)
  );

  assign byte_bad_s = rx_data_error;
  assign byte_ok_s  = rx_data_ready && !rx_data_error;
  assign is_lf_s    = (rx_data == CH_LF);

  // Byte is applied first; an idle gap is then judged against the resulting state.
  always_comb begin
    mid_state_s = state_q;
    state_d     = state_q;
    target_d    = target_q;
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    pt_d        = pt_q;
    key_valid_d = 1'b0;
    pt_valid_d  = 1'b0;
    cmd_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_bad_s) begin
          mid_state_s = ST_FLUSH;
          cmd_error_d = 1'b1;
        end else if (byte_ok_s) begin
          if (is_cmd_char(rx_data)) begin
            mid_state_s = ST_HEX;
            target_d    = cmd_target(rx_data);
            cnt_d       = {CW{1'b0}};
            asm_d       = {W{1'b0}};
          end else if (is_lf_s || (rx_data == CH_CR)) begin
            mid_state_s = ST_IDLE;
          end else begin
            mid_state_s = ST_FLUSH;
            cmd_error_d = 1'b1;
          end
        end else begin
          mid_state_s = ST_IDLE;
        end
      end

      ST_HEX: begin
        if (byte_bad_s) begin
          mid_state_s = ST_FLUSH;
          cmd_error_d = 1'b1;
        end else if (byte_ok_s) begin
          if (hex_valid_s) begin
            asm_d = {asm_q[W-5:0], hex_nib_s};
            cnt_d = (cnt_q == MAX_NIB) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};
            mid_state_s = (cnt_q == LAST_NIB) ? ST_EOL : ST_HEX;
          end else if (is_lf_s) begin
            mid_state_s = ST_IDLE;
            cmd_error_d = 1'b1;
          end else begin
            mid_state_s = ST_FLUSH;
            cmd_error_d = 1'b1;
          end
        end else begin
          mid_state_s = ST_HEX;
        end
      end

      ST_EOL: begin
        if (byte_bad_s) begin
          mid_state_s = ST_FLUSH;
          cmd_error_d = 1'b1;
        end else if (byte_ok_s) begin
          if (is_lf_s) begin
            mid_state_s = ST_IDLE;
            if (target_q == TGT_PT) begin
              pt_d       = asm_q;
              pt_valid_d = 1'b1;
            end else begin
              key_d       = asm_q;
              key_valid_d = 1'b1;
            end
          end else begin
            mid_state_s = ST_FLUSH;
            cmd_error_d = 1'b1;
          end
        end else begin
          mid_state_s = ST_EOL;
        end
      end

      ST_FLUSH: begin
        if (byte_ok_s && is_lf_s) begin
          mid_state_s = ST_IDLE;
        end else begin
          mid_state_s = ST_FLUSH;
        end
      end

      default: begin
        mid_state_s = ST_IDLE;
      end
    endcase

    if (rx_endofpacket) begin
      if ((mid_state_s == ST_HEX) || (mid_state_s == ST_EOL)) begin
        state_d     = ST_IDLE;
        cmd_error_d = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = mid_state_s;
    end
  end

  // State, payload and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      target_q    <= TGT_KEY;
      asm_q       <= {W{1'b0}};
      cnt_q       <= {CW{1'b0}};
      key_q       <= {W{1'b0}};
      pt_q        <= {W{1'b0}};
      key_valid_q <= 1'b0;
      pt_valid_q  <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      pt_q        <= pt_d;
      key_valid_q <= key_valid_d;
      pt_valid_q  <= pt_valid_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign key       = key_q;
  assign pt        = pt_q;
  assign key_valid = key_valid_q;
  assign pt_valid  = pt_valid_q;
  assign cmd_error = cmd_error_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_simpleserial_rx.sv
// Directed bench for simpleserial_rx with a line-level reference model and per-cycle compare.
module tb_simpleserial_rx;

  localparam int N = 16;
  localparam int W = 8 * N;

  logic         clk;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_data_ready;
  logic         rx_data_error;
  logic         rx_endofpacket;
  logic [W-1:0] key;
  logic         key_valid;
  logic [W-1:0] pt;
  logic         pt_valid;
  logic         cmd_error;
  logic         busy;

  simpleserial_rx #(.DATA_BYTES(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_data_ready  (rx_data_ready),
    .rx_data_error  (rx_data_error),
    .rx_endofpacket (rx_endofpacket),
    .key            (key),
    .key_valid      (key_valid),
    .pt             (pt),
    .pt_valid       (pt_valid),
    .cmd_error      (cmd_error),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int n_kv = 0, n_pv = 0, n_er = 0;

  // Reference model: a command is a line; payload built arithmetically from a nibble queue.
  bit           m_collect, m_flush, m_to_pt;
  int           m_nibs[$];
  logic [W-1:0] m_key, m_pt;
  logic [W-1:0] pend_key, pend_pt, exp_key, exp_pt;
  logic         pend_kv, pend_pv, pend_er, pend_busy;
  logic         exp_kv, exp_pv, exp_er, exp_busy;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    string digits = "0123456789abcdef";
    logic [7:0] lc;
    lc = (c >= 8'h41 && c <= 8'h5A) ? c + 8'd32 : c;
    for (int i = 0; i < 16; i++) if (digits[i] == lc) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_collect = 0; m_flush = 0; m_to_pt = 0; m_nibs.delete();
    m_key = '0; m_pt = '0;
    pend_key = '0; pend_pt = '0; pend_kv = 0; pend_pv = 0; pend_er = 0; pend_busy = 0;
  endtask

  task automatic model_step(input logic rdy, input logic [7:0] d, input logic derr, input logic eop);
    logic [W-1:0] val;
    pend_kv = 0; pend_pv = 0; pend_er = 0;
    if (derr) begin
      if (!m_flush) begin
        m_collect = 0; m_flush = 1; pend_er = 1;
      end
    end else if (rdy) begin
      if (m_flush) begin
        if (d == 8'h0A) m_flush = 0;
      end else if (!m_collect) begin
        if (d == 8'h6B || d == 8'h70) begin
          m_collect = 1; m_to_pt = (d == 8'h70); m_nibs.delete();
        end else if (d != 8'h0A && d != 8'h0D) begin
          m_flush = 1; pend_er = 1;
        end
      end else if (m_nibs.size() < 2 * N) begin
        if (hexval(d) >= 0) m_nibs.push_back(hexval(d));
        else if (d == 8'h0A) begin m_collect = 0; pend_er = 1; end
        else begin m_collect = 0; m_flush = 1; pend_er = 1; end
      end else begin
        if (d == 8'h0A) begin
          val = '0;
          foreach (m_nibs[i]) val = (val << 4) | W'(m_nibs[i]);
          if (m_to_pt) begin m_pt = val; pend_pv = 1; end
          else begin m_key = val; pend_kv = 1; end
          m_collect = 0;
        end else begin
          m_collect = 0; m_flush = 1; pend_er = 1;
        end
      end
    end
    if (eop) begin
      if (m_collect) begin m_collect = 0; pend_er = 1; end
      else m_flush = 0;
    end
    pend_key = m_key; pend_pt = m_pt; pend_busy = m_collect || m_flush;
  endtask

  // Model expectations take effect at the same edge the DUT registers them.
  always @(posedge clk) begin
    exp_key <= pend_key; exp_pt <= pend_pt;
    exp_kv <= pend_kv; exp_pv <= pend_pv; exp_er <= pend_er; exp_busy <= pend_busy;
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("key", key, exp_key);
      chk("pt", pt, exp_pt);
      chk("key_valid", W'(key_valid), W'(exp_kv));
      chk("pt_valid", W'(pt_valid), W'(exp_pv));
      chk("cmd_error", W'(cmd_error), W'(exp_er));
      chk("busy", W'(busy), W'(exp_busy));
      chk("one_hot_strobe", W'(int'(key_valid) + int'(pt_valid) + int'(cmd_error) > 1), W'(0));
      if (key_valid) n_kv++;
      if (pt_valid) n_pv++;
      if (cmd_error) n_er++;
    end
  end

  task automatic drive(input logic rdy, input logic [7:0] d, input logic derr, input logic eop);
    @(negedge clk); #1;
    rx_data_ready = rdy; rx_data = d; rx_data_error = derr; rx_endofpacket = eop;
    model_step(rdy, d, derr, eop);
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; rx_data_ready = 0; rx_data = 8'h00; rx_data_error = 0; rx_endofpacket = 0;
    model_reset();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  int kv0, pv0, er0;
  task automatic mark();
    kv0 = n_kv; pv0 = n_pv; er0 = n_er;
  endtask

  initial begin
    rst = 1'b1; rx_data_ready = 0; rx_data = 8'h00; rx_data_error = 0; rx_endofpacket = 0;
    model_reset();
    exp_key = '0; exp_pt = '0; exp_kv = 0; exp_pv = 0; exp_er = 0; exp_busy = 0;
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);
    chk("reset_key", key, '0);
    chk("reset_pt", pt, '0);
    chk("reset_busy", W'(busy), W'(0));

    // Key load, first hex pair lands in the top byte.
    mark();
    send_byte(8'h6B); send_str("000102030405060708090A0B0C0D0E0F"); send_byte(8'h0A);
    idle(2);
    chk("s1_key", key, 128'h000102030405060708090A0B0C0D0E0F);
    chk("s1_pt", pt, '0);
    chk("s1_kv_pulses", W'(n_kv - kv0), W'(1));

    // Plaintext in upper then lower case.
    mark();
    send_byte(8'h70); for (int i = 0; i < 32; i++) send_byte(8'h41); send_byte(8'h0A);
    idle(1);
    chk("s2a_pt", pt, {16{8'hAA}});
    send_byte(8'h70); for (int i = 0; i < 32; i++) send_byte(8'h61); send_byte(8'h0A);
    idle(2);
    chk("s2b_pt", pt, {16{8'hAA}});
    chk("s2_pv_pulses", W'(n_pv - pv0), W'(2));

    // Short payload terminated by LF.
    mark();
    send_byte(8'h6B); for (int i = 0; i < 31; i++) send_byte(8'h37); send_byte(8'h0A);
    idle(2);
    chk("s3_err_pulses", W'(n_er - er0), W'(1));
    chk("s3_key_held", key, 128'h000102030405060708090A0B0C0D0E0F);
    chk("s3_busy", W'(busy), W'(0));

    // Bad hex char, flush, then a good command.
    mark();
    send_byte(8'h70); send_str("0123456789abcdef"); send_str("gxyz12"); send_byte(8'h0A);
    send_byte(8'h70); send_str("0123456789abcdefFEDCBA9876543210"); send_byte(8'h0A);
    idle(2);
    chk("s4_err_pulses", W'(n_er - er0), W'(1));
    chk("s4_pt", pt, 128'h0123456789ABCDEFFEDCBA9876543210);

    // Idle gap mid-payload.
    mark();
    send_byte(8'h6B); send_str("0123456789");
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    chk("s5_err_pulses", W'(n_er - er0), W'(1));
    chk("s5_busy", W'(busy), W'(0));

    // Reset mid-command, then a full key command.
    mark();
    send_byte(8'h6B); send_str("0123456789ABCDEF0123");
    do_reset();
    send_byte(8'h6B); send_str("DEADBEEF00112233445566778899CAFE"); send_byte(8'h0A);
    idle(2);
    chk("s6_key", key, 128'hDEADBEEF00112233445566778899CAFE);
    chk("s6_no_err", W'(n_er - er0), W'(0));
    chk("s6_pt_cleared", pt, '0);

    // Boundaries: CR/LF in idle, bad EOL char, framing error, gap coinciding with final LF.
    mark();
    send_byte(8'h0D); send_byte(8'h0A);
    send_byte(8'h6B); for (int i = 0; i < 32; i++) send_byte(8'h46); send_byte(8'h5A); send_byte(8'h0A);
    send_byte(8'h70); send_str("12"); drive(1'b1, 8'h33, 1'b1, 1'b0); send_byte(8'h0A);
    send_byte(8'h51); drive(1'b0, 8'h00, 1'b0, 1'b1);
    send_byte(8'h70); for (int i = 0; i < 32; i++) send_byte(8'h35); drive(1'b1, 8'h0A, 1'b0, 1'b1);
    idle(2);
    chk("s7_err_pulses", W'(n_er - er0), W'(3));
    chk("s7_key_held", key, 128'hDEADBEEF00112233445566778899CAFE);
    chk("s7_pt", pt, {16{8'h55}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
